// File: rtl/value_issuer.sv
// Buffers producer words in a small FIFO and issues each one as a one-cycle enable pulse,
// keeping value stable for HOLD cycles so the downstream accumulator never misses or repeats a word.
module value_issuer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int HOLD  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDTH-1:0]         in_data_i,
  input  logic                     flush_i,
  output logic                     enable_o,
  output logic [WIDTH-1:0]         value_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLD >= 2) ? HOLD - 2 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    HOLDING = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push;
  logic             pop;
  logic             has_word;

  // A full FIFO refuses input even when a pop frees a slot on the same edge.
  assign in_ready_o = (level_q != LW'(DEPTH)) && !flush_i;
  assign push       = in_valid_i && in_ready_o;
  assign has_word   = (level_q != '0) && !flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (has_word) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (HOLD == 1) begin
          if (has_word) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = HOLD_LOAD;
          state_d = HOLDING;
        end
      end
      HOLDING: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (has_word) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flush clears the buffer but lets the word already issued finish its window.
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    value_d  = pop ? mem_q[rd_ptr_q] : value_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  assign enable_o = (state_q == ISSUE);
  assign busy_o   = (state_q != IDLE);
  assign value_o  = value_q;
  assign level_o  = level_q;

endmodule

// File: doc/value_issuer.md
# value_issuer

Upstream feeder for the accumulator stage that consumes an `enable`/`value` pair. It accepts words on a valid/ready input, buffers them in a small FIFO, and presents each word as a one-cycle `enable` pulse. `value` is held stable long enough for the downstream three-state sequence (idle → state 1 → state 2 add) to sample it. This paces bursty producers to the accumulator's fixed acceptance rate so that no word is lost or double-added.

## Interface
- `WIDTH`, 32, data width of `in_data` and `value`
- `DEPTH`, 8, FIFO depth in words; a power of 2, at least 2
- `HOLD`, 3, cycles `value` stays stable from the `enable` cycle onward; equals the downstream cycles per accepted word; at least 1

- `CLK`  in  1  sole clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  producer has a word on `in_data`
- `in_ready`  out  1  block can accept a word; a transfer occurs on an edge where `in_valid & in_ready`
- `in_data`  in  WIDTH  word to buffer
- `flush`  in  1  synchronous discard of all buffered words
- `enable`  out  1  one-cycle issue pulse to downstream
- `value`  out  WIDTH  issued word
- `level`  out  clog2(DEPTH)+1  words currently buffered
- `busy`  out  1  issue sequence in progress (enable or hold cycles)

## Operation
- FIFO: circular buffer with read and write pointers and `level`. Pointers wrap modulo `DEPTH`.
- `in_ready = (level != DEPTH) & ~flush`, combinational.
  - When full, no push is taken, even if a pop happens on the same edge.
- Push on an edge with `in_valid & in_ready`: the word is written at the write pointer, the pointer advances, and `level` increments.
- Pop and push on the same edge: `level` is unchanged and both pointers advance.
- Issue FSM states:
  - IDLE: `busy=0`, `enable=0`. On an edge with `level>0` and no `flush`, pop the head into `value`, set `enable<=1`, go to ISSUE.
  - ISSUE: lasts one cycle with `enable=1`, `busy=1`. At the edge, `enable<=0`.
    - If `HOLD==1`: go to IDLE, or reissue directly if `level>0`.
    - Otherwise: load hold counter with `HOLD-2` and go to HOLDING.
  - HOLDING: `enable=0`, `busy=1`. The counter decrements each edge. At the edge where the counter is 0:
    - if `level>0` and no `flush`, pop the next word and go to ISSUE (back-to-back);
    - otherwise go to IDLE.
- `value` changes only on an issue edge. Between issues it retains the last issued word.
- `flush`, synchronous:
  - On the edge: pointers ← 0 and `level` ← 0.
  - An in-progress ISSUE/HOLDING completes normally; `value` is not disturbed.
  - No issue occurs on a flush edge.
- There is no bypass: a word pushed into an empty FIFO is never issued on the same edge.

## Timing
- Reset values (asynchronous, on assertion):
  - `enable=0`, `value=0`, `level=0`, `busy=0`, FSM in IDLE, pointers 0.
  - `in_ready=1` once reset is released (when `flush=0`).
- Latency: for a word accepted at edge E0 into an empty, idle block, `enable` is high in the cycle following E1. `value` is valid in that same cycle.
- Issue spacing: consecutive `enable` pulses are exactly `HOLD` cycles apart while the FIFO is non-empty. Peak throughput is 1 word per `HOLD` cycles.
- `value` is stable for `HOLD` consecutive cycles, starting with the `enable` cycle.
- With `DEPTH=8`, `HOLD=3`, a producer pushing every cycle from empty:
  - `in_ready` drops after 8 + floor(pops) accepted words.
  - In steady state, `in_ready` is high 1 cycle in every 3.
- Reset mid-hold: the sequence aborts immediately, all state is cleared, and the word being held is not reissued.
- Pointer wrap is exercised after `DEPTH` pushes. No special case applies.

## Test plan
- Reset then single word: push 0x0000_0005 at E0 → `enable` is high for exactly one cycle after E1, `value=5` for 3 cycles, `busy` low after 3 cycles, `level` returns to 0.
- Burst of 8 words (1..8), one per cycle → `enable` pulses every 3 cycles carrying 1..8 in order, and `value` is stable across each 3-cycle window. A downstream model summing the values reads 36.
- Fill to full: hold `in_valid=1` with 12 words while downstream issue runs → `in_ready` is low whenever `level==8`, no word is lost or duplicated, and the issue order equals the push order across pointer wrap.
- Flush during hold: 4 words buffered, assert `flush` one cycle into HOLDING → the current `value` is held to the end of its window, `level=0`, no further `enable`, and `in_ready` is low during the `flush` cycle.
- Async reset mid-ISSUE: assert `RST` between edges while `enable=1` → `enable`, `value`, `level` and `busy` go to 0 without waiting for a clock edge, and the block resumes correctly with a new push after release.
- Simultaneous push and pop at `level==3` → `level` stays 3 and the data order is preserved.
